// File: rtl/bb_skid_buf.sv
// Two-entry valid/ready skid buffer with fully registered outputs (in_ready, out_valid, out_data).
// Optional stall counter enabled by defining BB_SKID_BUF_STALL_CNT_EN; otherwise stall_cnt is tied to 0.
module bb_skid_buf #(
    parameter int              DW      = 2,
    parameter logic [DW-1:0]   RST_VAL = '0,
    parameter int              STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    // State bits are {out_valid, in_ready}, so both handshake outputs come straight off the state flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b01,
        S_BUSY  = 2'b11,
        S_FULL  = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [DW-1:0]   w_main_nxt;
    logic [DW-1:0]   w_skid_nxt;
    logic            w_in_fire;
    logic            w_out_fire;

    assign in_ready   = r_state[0];
    assign out_valid  = r_state[1];
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & r_state[0];
    assign w_out_fire = r_state[1] & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Beats in flight this cycle are deliberately dropped.
            w_state_nxt = S_EMPTY;
            w_main_nxt  = RST_VAL;
            w_skid_nxt  = RST_VAL;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = S_FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = S_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

`ifdef BB_SKID_BUF_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
